// File: rtl/reg_file.sv
// Register file: one synchronous write port, two combinational read ports,
// optional hard-wired zero entry, and a sequenced clear sweep that reports busy.
// Define REG_FILE_BYPASS_EN to forward an accepted write to matching read ports in the same cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | normal operation; writes accepted, clr starts a sweep
// ST_CLEAR | zeroing mem[ptr] each cycle, ptr from 0 to DEPTH-1; writes dropped
module reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              sweep;
    logic              wr_accept;
    logic [WIDTH-1:0]  mem [DEPTH];

    // FSM state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sweep   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                sweep = 1'b1;
                // ptr parks on the last entry instead of wrapping
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // clr in the same cycle as a write takes priority and drops the write
    assign wr_accept = we && (state_q == ST_IDLE) && !clr
                       && ({1'b0, waddr} < DEPTH_C)
                       && !(ZERO_REG && (waddr == '0));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sweep && (ptr_q == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_accept && (waddr == ADDR_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // read mux: out-of-range addresses and the zero entry return 0
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && (i == 0))) begin
                if (raddr_a == ADDR_W'(i)) rdata_a = mem[i];
                if (raddr_b == ADDR_W'(i)) rdata_b = mem[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_accept && (waddr == raddr_a)) rdata_a = wdata;
        if (wr_accept && (waddr == raddr_b)) rdata_b = wdata;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a plain array model checked every cycle,
// plus literal expectations for reset, writes, zero entry, bypass, clear and abort.
module tb_reg_file;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              n_reset;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;
    logic              clr;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .clr     (clr),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: contents, plus how many sweep edges remain
    int model_mem [DEPTH];
    int sweep_left;

    function automatic bit model_accept();
        return we && (sweep_left == 0) && !clr && (int'(waddr) < DEPTH) && (waddr != 0);
    endfunction

    function automatic int model_read(input int addr);
`ifdef REG_FILE_BYPASS_EN
        if (model_accept() && int'(waddr) == addr) return int'(wdata);
`endif
        if (addr == 0 || addr >= DEPTH) return 0;
        return model_mem[addr];
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            model_mem[DEPTH - sweep_left] = 0;
            sweep_left = sweep_left - 1;
        end else if (clr) begin
            sweep_left = DEPTH;
        end else if (model_accept()) begin
            model_mem[waddr] = int'(wdata);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model rdata_a", int'(rdata_a), model_read(int'(raddr_a)));
        chk("model rdata_b", int'(rdata_b), model_read(int'(raddr_b)));
        chk("model busy", int'(busy), (sweep_left > 0) ? 1 : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int d);
        we = 1'b1;
        waddr = ADDR_W'(a);
        wdata = WIDTH'(d);
        step();
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n_reset = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr = 1'b0;
        #12;
        n_reset = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = ADDR_W'(i);
            raddr_b = ADDR_W'(DEPTH - 1 - i);
            #1;
            chk("reset rdata_a", int'(rdata_a), 0);
            chk("reset rdata_b", int'(rdata_b), 0);
        end
        chk("reset busy", int'(busy), 0);

        write(3, 8'hA5);
        raddr_a = 3; raddr_b = 3;
        #1;
        chk("write3 rdata_a", int'(rdata_a), 8'hA5);
        chk("write3 rdata_b", int'(rdata_b), 8'hA5);

        write(0, 8'hFF);
        raddr_a = 0;
        #1;
        chk("zero entry", int'(rdata_a), 0);

        write(5, 8'h11);
        raddr_a = 5;
        we = 1'b1; waddr = 5; wdata = 8'h3C;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass before edge", int'(rdata_a), 8'h3C);
`else
        chk("no bypass before edge", int'(rdata_a), 8'h11);
`endif
        step();
        we = 1'b0;
        chk("after edge", int'(rdata_a), 8'h3C);

        // same-cycle clr and write: clr wins, write dropped
        for (int i = 1; i < DEPTH; i++) write(i, 16 * i + i);
        raddr_a = 2; raddr_b = 7;
        clr = 1'b1; we = 1'b1; waddr = 4; wdata = 8'hEE;
        step();
        clr = 1'b0; we = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            n++;
            we = (n == 4); waddr = 1; wdata = 8'h77;
            clr = (n == 5);
            step();
        end
        we = 1'b0; clr = 1'b0;
        chk("busy cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = ADDR_W'(i);
            #1;
            chk("after clear", int'(rdata_a), 0);
        end

        // reset in the middle of a sweep
        for (int i = 1; i < DEPTH; i++) write(i, 8'h80 + i);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step(); step(); step();
        raddr_a = 6;
        #1;
        chk("mid-sweep unswept entry", int'(rdata_a), 8'h86);
        #1;
        n_reset = 1'b0;
        #1;
        chk("reset busy mid-sweep", int'(busy), 0);
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = ADDR_W'(i);
            raddr_b = ADDR_W'(DEPTH - 1 - i);
            #1;
            chk("abort rdata_a", int'(rdata_a), 0);
            chk("abort rdata_b", int'(rdata_b), 0);
        end
        @(negedge clk);
        n_reset = 1'b1;
        write(6, 8'h5A);
        raddr_a = 6;
        #1;
        chk("first write after reset", int'(rdata_a), 8'h5A);
        chk("busy after reset", int'(busy), 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
